// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline stage with 2-entry skid buffer, flush and perf counters
module pipe_stage_reg #(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 4,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [NUM_LANES*DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0]           ctrl_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [NUM_LANES*DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0]           ctrl_o,
    input  logic                        flush_i,
    output logic [1:0]                  occupancy_o,
    input  logic                        clr_cnt_i,
    output logic [CNT_W-1:0]            stall_cnt_o,
    output logic [CNT_W-1:0]            bubble_cnt_o
);
    localparam int PW = NUM_LANES * DATA_W;

    logic              main_v, skid_v, accept, emit;
    logic [PW-1:0]     main_d, skid_d;
    logic [CTRL_W-1:0] main_c, skid_c;
    logic [CNT_W-1:0]  stall_q, bubble_q;

    assign ready_o      = !skid_v;
    assign valid_o      = main_v;
    assign data_o       = main_d;
    assign ctrl_o       = main_v ? main_c : '0;
    assign occupancy_o  = {1'b0, main_v} + {1'b0, skid_v};
    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
    assign accept       = valid_i & ready_o;
    assign emit         = main_v & ready_i;

    // Entry storage: flush kills both slots, skid drains into main first, otherwise load main or overflow into skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
            main_c <= '0;
            skid_c <= '0;
        end else if (flush_i) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (emit) begin
                main_d <= skid_d;
                main_c <= skid_c;
                skid_v <= 1'b0;
            end
        end else if (!main_v || emit) begin
            main_v <= accept;
            if (accept) begin
                main_d <= data_i;
                main_c <= ctrl_i;
            end
        end else if (accept) begin
            skid_v <= 1'b1;
            skid_d <= data_i;
            skid_c <= ctrl_i;
        end
    end

    // Saturating stall/bubble counters; clear takes priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= clr_cnt_i ? '0 : (main_v && !ready_i && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
            bubble_q <= clr_cnt_i ? '0 : (!main_v && ready_i && !(&bubble_q)) ? bubble_q + 1'b1 : bubble_q;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
    localparam int DATA_W = 32, NUM_LANES = 4, CTRL_W = 8, CNT_W = 4;
    localparam int PW = DATA_W * NUM_LANES;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic              valid_i = 1'b0, ready_i = 1'b0, flush_i = 1'b0, clr_cnt_i = 1'b0;
    logic [PW-1:0]     data_i = '0;
    logic [CTRL_W-1:0] ctrl_i = '0;
    logic              ready_o, valid_o;
    logic [PW-1:0]     data_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [1:0]        occupancy_o;
    logic [CNT_W-1:0]  stall_cnt_o, bubble_cnt_o;

    int total = 0, bad = 0, n_emit = 0, base;
    logic [PW+CTRL_W-1:0] q[$];
    logic [PW+CTRL_W-1:0] exp_e;

    pipe_stage_reg #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .ctrl_i(ctrl_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .ctrl_o(ctrl_o),
        .flush_i(flush_i), .occupancy_o(occupancy_o), .clr_cnt_i(clr_cnt_i),
        .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PW+CTRL_W-1:0] got, input logic [PW+CTRL_W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] mk(input int lane0);
        return {$urandom, $urandom, $urandom, lane0[31:0]};
    endfunction

    task automatic drive(input logic v, input int lane0, input logic [CTRL_W-1:0] c);
        valid_i = v;
        data_i  = mk(lane0);
        ctrl_i  = c;
    endtask

    // Scoreboard: compare emitted entries against queued accepts, track occupancy/ready/ctrl gating
    always @(negedge clk) begin
        if (!rst_n) q.delete();
        else begin
            chk("occupancy", occupancy_o, q.size());
            chk("ready_o", ready_o, q.size() < 2);
            if (!valid_o) chk("ctrl_gate", ctrl_o, 0);
            if (valid_o && ready_i) begin
                n_emit++;
                total++;
                assert (q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_emit got=%h expected=none", data_o);
                end
                if (q.size() != 0) begin
                    exp_e = q.pop_front();
                    chk("emit_entry", {ctrl_o, data_o}, exp_e);
                end
            end
            if (flush_i) q.delete();
            else if (valid_i && ready_o) q.push_back({ctrl_i, data_i});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_ctrl", ctrl_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_bubble", bubble_cnt_o, 0);

        // back-to-back stream
        ready_i = 1'b1;
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        base = n_emit;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, 8'hA5);
            chk("stream_ready", ready_o, 1);
            tick();
            chk("stream_valid", valid_o, 1);
            chk("stream_lane0", data_o[31:0], i);
            chk("stream_ctrl", ctrl_o, 8'hA5);
        end
        valid_i = 1'b0;
        tick();
        chk("stream_count", n_emit - base, 8);
        chk("stream_stall", stall_cnt_o, 0);

        // downstream stall for 3 cycles
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        base = n_emit;
        drive(1'b1, 32'hA, 8'h11);
        tick();
        ready_i = 1'b0;
        drive(1'b1, 32'hB, 8'h22);
        tick();
        chk("stall_occ", occupancy_o, 2);
        chk("stall_ready", ready_o, 0);
        drive(1'b1, 32'hC, 8'h33);
        tick();
        chk("stall_ready2", ready_o, 0);
        tick();
        chk("stall_cnt", stall_cnt_o, 3);
        chk("stall_occ2", occupancy_o, 2);
        ready_i = 1'b1;
        tick();
        chk("drain_lane0", data_o[31:0], 32'hB);
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        chk("stall_emits", n_emit - base, 3);

        // flush with two held entries and a concurrent offer
        ready_i = 1'b0;
        drive(1'b1, 32'hD, 8'h44);
        tick();
        drive(1'b1, 32'hE, 8'h55);
        tick();
        chk("pre_flush_occ", occupancy_o, 2);
        flush_i = 1'b1;
        drive(1'b1, 32'hF, 8'h66);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush_valid", valid_o, 0);
        chk("flush_ctrl", ctrl_o, 0);
        chk("flush_occ", occupancy_o, 0);
        chk("flush_ready", ready_o, 1);
        drive(1'b1, 32'h10, 8'h77);
        tick();
        flush_i = 1'b1;
        drive(1'b1, 32'h11, 8'h88);
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush1_occ", occupancy_o, 0);
        ready_i = 1'b1;
        base = n_emit;
        repeat (3) tick();
        chk("flush_no_emit", n_emit - base, 0);

        // stall counter saturation and clear
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        drive(1'b1, 32'h12, 8'h99);
        tick();
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (20) tick();
        chk("stall_sat", stall_cnt_o, 15);
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        chk("stall_clr", stall_cnt_o, 0);
        tick();
        chk("stall_after_clr", stall_cnt_o, 1);
        ready_i = 1'b1;
        repeat (2) tick();

        // asynchronous reset with two held entries
        ready_i = 1'b0;
        drive(1'b1, 32'h13, 8'hAA);
        tick();
        drive(1'b1, 32'h14, 8'hBB);
        tick();
        valid_i = 1'b0;
        chk("pre_rst_occ", occupancy_o, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_occ", occupancy_o, 0);
        chk("arst_ready", ready_o, 1);
        chk("arst_ctrl", ctrl_o, 0);
        chk("arst_data", data_o, 0);
        tick();
        rst_n = 1'b1;
        ready_i = 1'b1;
        repeat (5) tick();
        chk("bubble_cnt", bubble_cnt_o, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline stage register, the successor to the fixed ID/EX latch. It carries NUM_LANES data words plus a control bundle between two pipeline stages using a valid/ready handshake. A 2-entry skid buffer breaks the ready path combinationally. It also provides flush (bubble insertion), control gating on empty slots, and saturating stall/bubble performance counters.
Any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) is built by instantiating it with different widths.

Parameters:
DATA_W, 32, width of each data lane (inst, sign-ext imm, rs data, rt data ...)
NUM_LANES, 4, number of data lanes carried
CTRL_W, 8, width of control bundle (MemToReg, RegWrite, MemWrite, MemRead, ALUsrc, ALUop, regDst, spare)
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  upstream entry valid
ready_o  output  1  stage can accept an entry this cycle
data_i  input  NUM_LANES*DATA_W  lane 0 in bits [DATA_W-1:0], lane k at [k*DATA_W +: DATA_W]
ctrl_i  input  CTRL_W  upstream control bundle
valid_o  output  1  output entry valid
ready_i  input  1  downstream accepts (0 = downstream stall)
data_o  output  NUM_LANES*DATA_W  output lanes, same packing as data_i
ctrl_o  output  CTRL_W  output control bundle, all-zero whenever valid_o=0
flush_i  input  1  synchronous kill of all held entries
occupancy_o  output  2  number of held entries, 0..2
clr_cnt_i  input  1  synchronous clear of both counters
stall_cnt_o  output  CNT_W  cycles with valid_o=1 and ready_i=0
bubble_cnt_o  output  CNT_W  cycles with valid_o=0 and ready_i=1

Behaviour:
- Reset: asynchronous on rst_n low; clock and reset use the names clk / rst_n.
  - After reset: main_v=0, skid_v=0, data/ctrl registers 0, counters 0.
  - Outputs after reset: valid_o=0, ctrl_o=0, data_o=0, ready_o=1, occupancy_o=0.
  - Reset asserted mid-transfer discards all entries immediately.
- Storage: main register (drives outputs) and skid register, each with a valid bit.
  - ready_o = !skid_v, taken straight from a flop; no combinational path from ready_i.
- Transfer definitions: accept = valid_i & ready_o; emit = valid_o & ready_i.
- Per-cycle update when flush_i=0:
  - Main empty or emit, skid empty: on accept, input loads main; otherwise main_v <= 0 when emit.
  - Main full, no emit, accept: input loads skid; ready_o drops next cycle.
  - Emit with skid full: skid moves to main and skid_v <= 0. No accept is possible that cycle because ready_o=0.
  - Main full, no emit, no accept: hold all state.
- Latency and throughput: 1 cycle from accept to valid_o into an empty stage; sustained 1 entry/cycle when ready_i=1. Order is strictly FIFO.
- Output gating:
  - ctrl_o = main_v ? ctrl_q : 0, so an empty slot is a NOP bubble downstream.
  - data_o holds the last loaded value when invalid.
- Flush:
  - flush_i=1 has highest priority. Next cycle main_v=0 and skid_v=0; any concurrent accept is discarded.
  - ready_o=1 in the cycle after flush.
  - Data registers are not cleared; counters are unaffected.
  - A flush coinciding with emit still counts as emitted this cycle; downstream sees that entry.
- Counters:
  - Each is saturating at 2^CNT_W-1 and never wraps.
  - Update based on the current-cycle valid_o/ready_i.
  - clr_cnt_i wins over increment: value is 0 next cycle.
- occupancy_o = main_v + skid_v (registered state).
- No X propagation: every register is reset.

Test Plan:
- Reset with DATA_W=32, NUM_LANES=4: release rst_n -> valid_o=0, ready_o=1, ctrl_o=0, occupancy_o=0, counters 0.
- Stream 8 entries back-to-back, lane0=i, ctrl=8'hA5, ready_i=1 -> valid_o from cycle 1, lane0 0..7 on consecutive cycles, ready_o stays 1, stall_cnt=0.
- Drop ready_i for 3 cycles during a stream -> second entry lands in skid, occupancy_o=2, ready_o=0 for those cycles, stall_cnt=3. On ready_i=1, entries exit in order with no loss or duplication.
- Flush with occupancy 2 and a concurrent valid_i -> next cycle valid_o=0, ctrl_o=0, occupancy_o=0, ready_o=1; the concurrent entry never appears.
- CNT_W=4 with valid_o=1 and ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15. clr_cnt_i together with an increment -> 0.
- Assert rst_n low asynchronously mid-cycle with occupancy 2 -> outputs reset immediately without waiting for a clock edge; bubble_cnt counts idle ready_i=1 cycles after release.
